// File: rtl/multicast_scheduler_pkg.sv
// multicast_scheduler_pkg
// Shared definitions for the multicast bus scheduler:
//   - state encoding of the sequencer (IDLE / CONFIG / RUN)
//   - default packet field widths and a helper for the packed packet width
package multicast_scheduler_pkg;

   localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
   localparam logic [1:0] ST_CONFIG_ENC = 2'd1;
   localparam logic [1:0] ST_RUN_ENC    = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = ST_IDLE_ENC,
      ST_CONFIG = ST_CONFIG_ENC,
      ST_RUN    = ST_RUN_ENC
   } state_t;

   localparam int DEF_ID_LEN    = 4;
   localparam int DEF_VALUE_LEN = 32;

   // A queued packet is stored as {tag, value}.
   function automatic int pkt_width(input int id_len, input int value_len);
      return id_len + value_len;
   endfunction

endpackage

// File: rtl/mc_pkt_fifo.sv
// mc_pkt_fifo
// Synchronous show-ahead FIFO holding queued (tag, value) packets.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the queue)
//   push, din     write request and data; ignored while full
//   pop           read request; ignored while empty
//   dout          current head entry, valid whenever empty is low
//   full, empty   occupancy flags
module mc_pkt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 36
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra pointer bit distinguishes full from empty when the indices match.
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage carries no reset; only the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
   end

   // Show-ahead: the head is visible without a read request.
   assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/multicast_scheduler.sv
// multicast_scheduler
// Sequencer for one multicast bus: programs controller IDs through the
// set_id/id_in scan chain, then issues queued (tag, value) packets on the
// shared bus, completing each transfer on the aggregated bus_ready. A stall
// timeout drops packets whose tag matches no controller.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cfg_start                     begin (or restart) ID programming
//   cfg_id_valid/cfg_id/cfg_id_ready  ID word handshake
//   cfg_done                      all NUM_NODES IDs shifted in
//   set_id, id_out                scan-chain strobe and head id_in
//   pkt_valid/pkt_tag/pkt_value/pkt_ready  packet queue handshake
//   tag, enable, value            multicast bus outputs
//   bus_ready                     OR of the controllers' ready_out
//   drop                          head packet dropped by timeout (pulse)
module multicast_scheduler
   import multicast_scheduler_pkg::*;
#(
   parameter int ID_LEN     = DEF_ID_LEN,
   parameter int VALUE_LEN  = DEF_VALUE_LEN,
   parameter int NUM_NODES  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_start,
   input  logic                 cfg_id_valid,
   input  logic [ID_LEN-1:0]    cfg_id,
   output logic                 cfg_id_ready,
   output logic                 cfg_done,
   output logic                 set_id,
   output logic [ID_LEN-1:0]    id_out,
   input  logic                 pkt_valid,
   input  logic [ID_LEN-1:0]    pkt_tag,
   input  logic [VALUE_LEN-1:0] pkt_value,
   output logic                 pkt_ready,
   output logic [ID_LEN-1:0]    tag,
   output logic                 enable,
   output logic [VALUE_LEN-1:0] value,
   input  logic                 bus_ready,
   output logic                 drop
);

   localparam int PKT_W = pkt_width(ID_LEN, VALUE_LEN);
   localparam int CNT_W = $clog2(NUM_NODES + 1);
   localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] NODES_LAST = CNT_W'(NUM_NODES);
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t              state_reg;
   logic [CNT_W-1:0]    node_cnt_reg;
   logic [CNT_W-1:0]    node_cnt_next;
   logic [TO_W-1:0]     to_cnt_reg;
   logic                cfg_done_reg;
   logic                set_id_reg;
   logic [ID_LEN-1:0]   id_out_reg;

   logic                fifo_full;
   logic                fifo_empty;
   logic [PKT_W-1:0]    fifo_head;
   logic                start_ok;
   logic                id_hs;
   logic                last_hs;
   logic                push;
   logic                pop;
   logic                stall;

   // A restart is refused while packets are still queued in RUN, so no
   // queued traffic is stranded by reprogramming.
   assign start_ok = cfg_start &&
                     ((state_reg != ST_RUN) || fifo_empty);

   assign cfg_id_ready = (state_reg == ST_CONFIG);
   assign id_hs        = cfg_id_valid && cfg_id_ready;

   // A restart clears the count; an ID accepted in the same cycle counts
   // as the first of the new pass.
   assign node_cnt_next = (start_ok ? '0 : node_cnt_reg) + CNT_W'(id_hs);
   assign last_hs       = id_hs && (node_cnt_next == NODES_LAST);

   assign pkt_ready = (state_reg == ST_RUN) && !fifo_full && !cfg_start;
   assign push      = pkt_valid && pkt_ready;
   assign enable    = (state_reg == ST_RUN) && !fifo_empty;
   assign stall     = enable && !bus_ready;

   generate
      if (TIMEOUT == 0) begin : g_no_timeout
         assign drop = 1'b0;
      end else begin : g_timeout
         // to_cnt_reg holds the stalled cycles already seen, so the
         // TIMEOUT-th stalled cycle is the one where it reads TIMEOUT-1.
         assign drop = stall && (to_cnt_reg == TO_LAST);
      end
   endgenerate

   assign pop = (enable && bus_ready) || drop;

   assign tag    = enable ? fifo_head[PKT_W-1 -: ID_LEN] : '0;
   assign value  = enable ? fifo_head[VALUE_LEN-1:0]     : '0;
   assign set_id   = set_id_reg;
   assign id_out   = id_out_reg;
   assign cfg_done = cfg_done_reg;

   mc_pkt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PKT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({pkt_tag, pkt_value}),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         node_cnt_reg <= '0;
         to_cnt_reg   <= '0;
         cfg_done_reg <= 1'b0;
         set_id_reg   <= 1'b0;
         id_out_reg   <= '0;
      end else begin
         // Scan-chain strobe is a one-cycle pulse per accepted ID word.
         set_id_reg <= id_hs;
         if (id_hs) id_out_reg <= cfg_id;

         node_cnt_reg <= node_cnt_next;

         if (start_ok) begin
            state_reg    <= ST_CONFIG;
            cfg_done_reg <= 1'b0;
         end
         if (last_hs) begin
            state_reg    <= ST_RUN;
            cfg_done_reg <= 1'b1;
         end

         if (pop || !enable) begin
            to_cnt_reg <= '0;
         end else if (stall) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_multicast_scheduler.sv
// Self-checking bench for multicast_scheduler (NUM_NODES=4, FIFO_DEPTH=4,
// TIMEOUT=16). Inputs change on the falling edge, outputs are sampled 1 time
// unit later, well away from the rising edge.
module tb_multicast_scheduler;

   logic        clk;
   logic        rst;
   logic        cfg_start;
   logic        cfg_id_valid;
   logic [3:0]  cfg_id;
   logic        cfg_id_ready;
   logic        cfg_done;
   logic        set_id;
   logic [3:0]  id_out;
   logic        pkt_valid;
   logic [3:0]  pkt_tag;
   logic [31:0] pkt_value;
   logic        pkt_ready;
   logic [3:0]  tag;
   logic        enable;
   logic [31:0] value;
   logic        bus_ready;
   logic        drop;

   int n_checks = 0;
   int n_pass   = 0;

   multicast_scheduler #(
      .ID_LEN     (4),
      .VALUE_LEN  (32),
      .NUM_NODES  (4),
      .FIFO_DEPTH (4),
      .TIMEOUT    (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_start    (cfg_start),
      .cfg_id_valid (cfg_id_valid),
      .cfg_id       (cfg_id),
      .cfg_id_ready (cfg_id_ready),
      .cfg_done     (cfg_done),
      .set_id       (set_id),
      .id_out       (id_out),
      .pkt_valid    (pkt_valid),
      .pkt_tag      (pkt_tag),
      .pkt_value    (pkt_value),
      .pkt_ready    (pkt_ready),
      .tag          (tag),
      .enable       (enable),
      .value        (value),
      .bus_ready    (bus_ready),
      .drop         (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the controller scan chain: node 0 is the head fed by id_out.
   logic [3:0] chain [4];
   always @(posedge clk) begin
      if (set_id) begin
         chain[0] <= id_out;
         for (int i = 1; i < 4; i++) chain[i] <= chain[i-1];
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        valid;
      logic [3:0]  ptag;
      logic [31:0] pval;
      logic        br;
      logic        e_pr;
      logic        e_en;
      logic [3:0]  e_tag;
      logic [31:0] e_val;
      logic        e_drop;
   } vec_t;

   vec_t vecs [16];

   function automatic vec_t mk(input logic v, input logic [3:0] t, input logic [31:0] d,
                               input logic br, input logic pr, input logic en,
                               input logic [3:0] et, input logic [31:0] ev);
      vec_t r;
      r.valid = v;  r.ptag = t;  r.pval = d;  r.br = br;
      r.e_pr = pr;  r.e_en = en; r.e_tag = et; r.e_val = ev; r.e_drop = 1'b0;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic chk_all_zero(input string tagname);
      chk({tagname, ".set_id"},       set_id,       0);
      chk({tagname, ".id_out"},       id_out,       0);
      chk({tagname, ".cfg_done"},     cfg_done,     0);
      chk({tagname, ".cfg_id_ready"}, cfg_id_ready, 0);
      chk({tagname, ".pkt_ready"},    pkt_ready,    0);
      chk({tagname, ".enable"},       enable,       0);
      chk({tagname, ".tag"},          tag,          0);
      chk({tagname, ".value"},        value,        0);
      chk({tagname, ".drop"},         drop,         0);
   endtask

   // Starts programming, then offers four IDs on consecutive cycles and
   // checks the set_id pulse train and cfg_done timing.
   task automatic run_config(input logic [3:0] i0, input logic [3:0] i1,
                             input logic [3:0] i2, input logic [3:0] i3);
      logic [3:0] ids [4];
      ids[0] = i0; ids[1] = i1; ids[2] = i2; ids[3] = i3;
      @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      #1;
      chk("cfg.id_ready_in_config", cfg_id_ready, 1);
      chk("cfg.done_cleared", cfg_done, 0);
      chk("cfg.pkt_ready_in_config", pkt_ready, 0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         if (i < 4) begin
            cfg_id_valid = 1'b1;
            cfg_id       = ids[i];
         end else begin
            cfg_id_valid = 1'b0;
         end
         #1;
         chk($sformatf("cfg.set_id[%0d]", i), set_id, (i > 0) ? 1 : 0);
         if (i > 0) chk($sformatf("cfg.id_out[%0d]", i), id_out, ids[i-1]);
         chk($sformatf("cfg.done[%0d]", i), cfg_done, (i == 4) ? 1 : 0);
         $display("cfg step %0d: set_id=%0d id_out=%0d cfg_done=%0d", i, set_id, id_out, cfg_done);
      end
      @(negedge clk);
      #1;
      chk("cfg.set_id_low_after", set_id, 0);
      chk("cfg.id_ready_in_run", cfg_id_ready, 0);
      chk("cfg.pkt_ready_in_run", pkt_ready, 1);
      for (int n = 0; n < 4; n++)
         chk($sformatf("cfg.chain[%0d]", n), chain[n], ids[3-n]);
   endtask

   initial begin
      rst = 1'b1;
      cfg_start = 1'b0; cfg_id_valid = 1'b0; cfg_id = '0;
      pkt_valid = 1'b0; pkt_tag = '0; pkt_value = '0; bus_ready = 1'b0;

      // Streaming then backpressure; expected values worked out by hand.
      vecs[0]  = mk(1, 1, 32'hA,  1, 1, 0, 0, 32'h0);
      vecs[1]  = mk(1, 2, 32'hB,  1, 1, 1, 1, 32'hA);
      vecs[2]  = mk(1, 3, 32'hC,  1, 1, 1, 2, 32'hB);
      vecs[3]  = mk(0, 0, 32'h0,  1, 1, 1, 3, 32'hC);
      vecs[4]  = mk(0, 0, 32'h0,  1, 1, 0, 0, 32'h0);
      vecs[5]  = mk(1, 4, 32'h10, 0, 1, 0, 0, 32'h0);
      vecs[6]  = mk(1, 5, 32'h11, 0, 1, 1, 4, 32'h10);
      vecs[7]  = mk(1, 6, 32'h12, 0, 1, 1, 4, 32'h10);
      vecs[8]  = mk(1, 7, 32'h13, 0, 1, 1, 4, 32'h10);
      vecs[9]  = mk(1, 8, 32'h14, 0, 0, 1, 4, 32'h10);
      vecs[10] = mk(1, 8, 32'h14, 1, 0, 1, 4, 32'h10);
      vecs[11] = mk(1, 8, 32'h14, 1, 1, 1, 5, 32'h11);
      vecs[12] = mk(0, 0, 32'h0,  1, 1, 1, 6, 32'h12);
      vecs[13] = mk(0, 0, 32'h0,  1, 1, 1, 7, 32'h13);
      vecs[14] = mk(0, 0, 32'h0,  1, 1, 1, 8, 32'h14);
      vecs[15] = mk(0, 0, 32'h0,  1, 1, 0, 0, 32'h0);

      #2;
      chk_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle.id_ready", cfg_id_ready, 0);
      chk("idle.pkt_ready", pkt_ready, 0);

      run_config(4'd3, 4'd2, 4'd1, 4'd0);

      for (int v = 0; v < 16; v++) begin
         @(negedge clk);
         pkt_valid = vecs[v].valid;
         pkt_tag   = vecs[v].ptag;
         pkt_value = vecs[v].pval;
         bus_ready = vecs[v].br;
         #1;
         chk($sformatf("vec%0d.pkt_ready", v), pkt_ready, vecs[v].e_pr);
         chk($sformatf("vec%0d.enable", v),    enable,    vecs[v].e_en);
         chk($sformatf("vec%0d.tag", v),       tag,       vecs[v].e_tag);
         chk($sformatf("vec%0d.value", v),     value,     vecs[v].e_val);
         chk($sformatf("vec%0d.drop", v),      drop,      vecs[v].e_drop);
         $display("vec %0d: pkt_ready=%0d enable=%0d tag=%0d value=0x%0h", v, pkt_ready, enable, tag, value);
      end

      // Timeout with a single unmatched packet.
      @(negedge clk);
      bus_ready = 1'b0; pkt_valid = 1'b1; pkt_tag = 4'd9; pkt_value = 32'h99;
      #1;
      chk("to1.pkt_ready", pkt_ready, 1);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         pkt_valid = 1'b0;
         #1;
         chk($sformatf("to1.enable[%0d]", k), enable, 1);
         chk($sformatf("to1.drop[%0d]", k), drop, (k == 16) ? 1 : 0);
      end
      @(negedge clk);
      #1;
      chk("to1.enable_after", enable, 0);
      chk("to1.drop_after", drop, 0);
      $display("timeout single: dropped tag 9, enable=%0d", enable);

      // Timeout with a second packet queued behind the unmatched one.
      @(negedge clk);
      pkt_valid = 1'b1; pkt_tag = 4'd9; pkt_value = 32'h99;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 1) begin
            pkt_valid = 1'b1; pkt_tag = 4'd5; pkt_value = 32'h55;
         end else begin
            pkt_valid = 1'b0;
         end
         #1;
         if (k >= 15) chk($sformatf("to2.tag[%0d]", k), tag, 9);
         chk($sformatf("to2.drop[%0d]", k), drop, (k == 16) ? 1 : 0);
      end
      @(negedge clk);
      pkt_valid = 1'b0;
      #1;
      chk("to2.enable_next", enable, 1);
      chk("to2.tag_next", tag, 5);
      chk("to2.value_next", value, 32'h55);
      chk("to2.drop_next", drop, 0);
      @(negedge clk);
      bus_ready = 1'b1;
      #1;
      chk("to2.drain_tag", tag, 5);
      @(negedge clk);
      #1;
      chk("to2.drained", enable, 0);
      $display("timeout queued: next packet tag 5 issued after drop");

      // cfg_start in RUN with two packets queued is ignored.
      @(negedge clk);
      bus_ready = 1'b0; pkt_valid = 1'b1; pkt_tag = 4'd2; pkt_value = 32'h22;
      #1;
      chk("rs.push1_ready", pkt_ready, 1);
      @(negedge clk);
      pkt_tag = 4'd3; pkt_value = 32'h33;
      #1;
      chk("rs.head_tag", tag, 2);
      @(negedge clk);
      pkt_valid = 1'b0; cfg_start = 1'b1;
      #1;
      chk("rs.pkt_ready_during_start", pkt_ready, 0);
      @(negedge clk);
      cfg_start = 1'b0;
      #1;
      chk("rs.id_ready_still_run", cfg_id_ready, 0);
      chk("rs.cfg_done_kept", cfg_done, 1);
      chk("rs.enable_kept", enable, 1);
      chk("rs.pkt_ready_run", pkt_ready, 1);
      @(negedge clk);
      bus_ready = 1'b1;
      #1;
      chk("rs.drain0_tag", tag, 2);
      @(negedge clk);
      #1;
      chk("rs.drain1_tag", tag, 3);
      chk("rs.drain1_value", value, 32'h33);
      @(negedge clk);
      #1;
      chk("rs.drained", enable, 0);
      $display("restart in RUN ignored with 2 queued packets");

      // Reset in the middle of CONFIG after two IDs.
      @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0; cfg_id_valid = 1'b1; cfg_id = 4'd7;
      #1;
      chk("mr.id_ready", cfg_id_ready, 1);
      chk("mr.done_cleared", cfg_done, 0);
      @(negedge clk);
      cfg_id = 4'd6;
      #1;
      chk("mr.set_id", set_id, 1);
      chk("mr.id_out", id_out, 7);
      @(negedge clk);
      cfg_id_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk_all_zero("midreset");
      $display("reset asserted mid-config");
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mr.idle_id_ready", cfg_id_ready, 0);

      run_config(4'hA, 4'hB, 4'hC, 4'hD);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multicast_scheduler.md
# multicast_scheduler

Sequencer for one multicast bus of the PE array. It first programs the controller IDs by shifting them through the `set_id`/`id_in` scan chain. It then issues queued (tag, value) packets onto the shared bus, driving `tag`, `enable` and `value`, and completes each transfer on the aggregated `ready` returned by the tagged controllers. A stall timeout drops packets whose tag matches no controller, so the bus never deadlocks.

## Interface
Parameters:
- `ID_LEN`, 4, width of IDs and tags
- `VALUE_LEN`, 32, payload width
- `NUM_NODES`, 8, number of controllers on the scan chain (≥1)
- `FIFO_DEPTH`, 4, packet queue depth (power of two, ≥2)
- `TIMEOUT`, 16, consecutive stalled cycles before the head packet is dropped; 0 disables the timeout

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  async reset, active-high
- `cfg_start`  in  1  begin ID programming
- `cfg_id_valid`  in  1  ID word offered
- `cfg_id`  in  ID_LEN  ID word
- `cfg_id_ready`  out  1  ID word accepted when high with `cfg_id_valid`
- `cfg_done`  out  1  all NUM_NODES IDs shifted in
- `set_id`  out  1  scan-chain shift strobe
- `id_out`  out  ID_LEN  scan-chain head `id_in`
- `pkt_valid`  in  1  packet offered
- `pkt_tag`  in  ID_LEN  destination tag
- `pkt_value`  in  VALUE_LEN  payload
- `pkt_ready`  out  1  packet accepted when high with `pkt_valid`
- `tag`  out  ID_LEN  bus tag
- `enable`  out  1  bus enable
- `value`  out  VALUE_LEN  bus value
- `bus_ready`  in  1  OR of the controllers' `ready_out`
- `drop`  out  1  head packet dropped by timeout (1-cycle pulse)

## Operation
- States: IDLE, CONFIG, RUN. Reset enters IDLE.
- `cfg_start` is honoured in IDLE, CONFIG, or RUN with an empty FIFO. It is ignored otherwise.
- Honouring `cfg_start`: go to CONFIG, clear the node counter and clear `cfg_done`. A `cfg_start` in CONFIG restarts the count, but IDs already shifted stay in the chain.
- CONFIG behaviour:
  - `cfg_id_ready` = 1.
  - Each handshake registers `id_out` = `cfg_id` and pulses `set_id` for one cycle, then increments the counter.
  - The first accepted ID ends at the node farthest from the head; the last accepted ID ends at the head node.
  - When the NUM_NODES-th handshake occurs: go to RUN and set `cfg_done` = 1.
- RUN behaviour:
  - `pkt_ready` = !full && !`cfg_start`.
  - `enable` = !empty. `tag`/`value` = FIFO head while `enable` is high, and 0 while it is low.
  - A transfer completes on a cycle with `enable` && `bus_ready`; the head is popped.
  - Push and pop in the same cycle are both performed. When full, `pkt_ready` = 0 (no same-cycle bypass).
- Timeout: a counter counts consecutive cycles with `enable` = 1 and `bus_ready` = 0.
  - On the TIMEOUT-th such cycle the head is popped and `drop` = 1 in that cycle.
  - The counter clears on any pop, and whenever `enable` = 0.
- IDLE and CONFIG: `pkt_ready` = 0 and `enable` = 0.
- Reset values: state IDLE, FIFO empty, counters 0. Outputs `set_id`, `id_out`, `cfg_done`, `cfg_id_ready`, `pkt_ready`, `enable`, `tag`, `value` and `drop` are all 0.
- Reset mid-CONFIG or mid-RUN discards queued packets and the programming progress. Controller IDs are not cleared by this block.

## Timing
- ID handshake at cycle t: `set_id` = 1 and `id_out` = ID at t+1. `set_id` never stays high for two cycles on a single handshake.
- Back-to-back ID handshakes give a `set_id` pulse every cycle.
- The NUM_NODES-th handshake at t: state is RUN and `cfg_done` = 1 from t+1. The last `set_id` pulse is also at t+1.
- Packet push at t into an empty FIFO: `enable` rises at t+1. Minimum push-to-bus latency is 1 cycle.
- Sustained throughput is 1 packet per cycle while `bus_ready` stays high.
- `pkt_ready`, `enable`, `drop` and `cfg_id_ready` are combinational from registered state. The bus outputs do not combinationally depend on `bus_ready`.

## Structure
- Shared package: the state encoding localparams (IDLE/CONFIG/RUN) and the packet field widths.
- One sub-module: `mc_pkt_fifo`, a synchronous FIFO that is FIFO_DEPTH entries deep and ID_LEN+VALUE_LEN bits wide, with full/empty flags and a show-ahead head.
- This block holds the FSM, the node counter (width $clog2(NUM_NODES+1)) and the timeout counter (width $clog2(TIMEOUT+1)).

## Test plan
- Config, NUM_NODES=4: `cfg_start`, then IDs 3,2,1,0 on consecutive cycles -> 4 consecutive `set_id` pulses with `id_out` 3,2,1,0. `cfg_done` = 1 one cycle after the 4th handshake; chain node0..3 holds 0,1,2,3.
- Streaming: push tags 1,2,3 (values 0xA,0xB,0xC) with `bus_ready` = 1 -> `enable` high 3 consecutive cycles starting 1 cycle after the first push, with tag/value 1/0xA, 2/0xB, 3/0xC.
- Backpressure, FIFO_DEPTH=4: `bus_ready` = 0, push 5 packets -> `pkt_ready` drops after the 4th. Then raise `bus_ready` -> packets are drained in order and the 5th is accepted.
- Timeout, TIMEOUT=16: push tag 9 with `bus_ready` held 0 -> `drop` pulses on the 16th stalled cycle, `enable` falls the next cycle, and the next queued packet is issued.
- Restart rules: `cfg_start` in RUN with 2 packets queued -> ignored, state stays RUN. Assert `rst` mid-CONFIG after 2 IDs -> all outputs 0. A fresh config then needs 4 IDs.
